// File: rtl/opl3_pkg.sv
// opl3_pkg: shared widths and the frame FSM state type for the channel accumulator.
package opl3_pkg;

   localparam int NUM_OPERATORS = 36;
   localparam int OP_OUT_WIDTH  = 13;
   localparam int SAMPLE_WIDTH  = 16;
   // Headroom bits so a full frame of 63 extreme beats cannot wrap.
   localparam int ACC_GUARD     = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_SAT,
      ST_OUTPUT
   } acc_state_t;

endpackage

// File: rtl/sample_saturate.sv
// sample_saturate: clamps a signed value into a narrower signed range and flags clipping.
module sample_saturate #(
   parameter int IN_W  = 19,
   parameter int OUT_W = 16
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout,
   output logic                    clipped
);

   if (IN_W > OUT_W) begin : g_clamp
      localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

      always_comb begin
         dout    = din[OUT_W-1:0];
         clipped = 1'b0;
         if (din > MAX_V) begin
            dout    = MAX_V[OUT_W-1:0];
            clipped = 1'b1;
         end else if (din < MIN_V) begin
            dout    = MIN_V[OUT_W-1:0];
            clipped = 1'b1;
         end
      end
   end else begin : g_pass
      assign dout    = OUT_W'(din);
      assign clipped = 1'b0;
   end

endmodule

// File: rtl/channel_accumulator.sv
// channel_accumulator: sums carrier operator beats into left/right samples once per frame.
// Optional clip counter output enabled by defining CHANNEL_ACCUMULATOR_CLIP_CNT_EN.
module channel_accumulator
   import opl3_pkg::*;
#(
   parameter int NUM_OPS  = NUM_OPERATORS,
   parameter int OP_W     = OP_OUT_WIDTH,
   parameter int SAMPLE_W = SAMPLE_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       sample_clk_en,
   input  logic                       op_valid,
   input  logic signed [OP_W-1:0]     op_out,
   input  logic                       op_carrier,
   input  logic                       op_left,
   input  logic                       op_right,
   output logic signed [SAMPLE_W-1:0] sample_l,
   output logic signed [SAMPLE_W-1:0] sample_r,
   output logic                       sample_valid,
   output logic                       frame_err
`ifdef CHANNEL_ACCUMULATOR_CLIP_CNT_EN
   ,
   output logic [15:0]                clip_cnt
`endif
);

   localparam int ACC_W = OP_W + ACC_GUARD;
   localparam int CNT_W = 6;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_OPS);

   acc_state_t state, state_next;

   logic signed [ACC_W-1:0]    acc_l, acc_r;
   logic signed [ACC_W-1:0]    acc_base_l, acc_base_r;
   logic signed [ACC_W-1:0]    add_l, add_r, op_ext;
   logic [CNT_W-1:0]           cnt, cnt_inc;
   logic                       beat_last;
   logic                       pending, pending_next;
   logic                       frame_clr, beat_acc, load, err_set;
   logic signed [SAMPLE_W-1:0] sat_l, sat_r;
   logic                       clip_l, clip_r;

   // A frame (re)start counts from zero, so a beat in the opening cycle is beat 1.
   assign cnt_inc   = ((state == ST_ACCUM && !sample_clk_en) ? cnt : '0) + CNT_W'(1);
   assign beat_last = (cnt_inc == LAST_BEAT);

   assign op_ext     = {{ACC_GUARD{op_out[OP_W-1]}}, op_out};
   assign acc_base_l = frame_clr ? '0 : acc_l;
   assign acc_base_r = frame_clr ? '0 : acc_r;
   assign add_l      = (beat_acc && op_carrier && op_left)  ? op_ext : '0;
   assign add_r      = (beat_acc && op_carrier && op_right) ? op_ext : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         pending <= 1'b0;
      end else begin
         state   <= state_next;
         pending <= pending_next;
      end
   end

   always_comb begin
      state_next   = state;
      pending_next = pending;
      frame_clr    = 1'b0;
      beat_acc     = 1'b0;
      load         = 1'b0;
      sample_valid = 1'b0;
      err_set      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sample_clk_en || pending) begin
               frame_clr    = 1'b1;
               pending_next = 1'b0;
               beat_acc     = op_valid;
               state_next   = (op_valid && beat_last) ? ST_SAT : ST_ACCUM;
            end else begin
               err_set = op_valid;
            end
         end
         ST_ACCUM: begin
            frame_clr = sample_clk_en;
            err_set   = sample_clk_en;
            beat_acc  = op_valid;
            if (op_valid && beat_last) state_next = ST_SAT;
         end
         ST_SAT: begin
            load         = 1'b1;
            err_set      = op_valid;
            pending_next = pending | sample_clk_en;
            state_next   = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            sample_valid = 1'b1;
            err_set      = op_valid;
            pending_next = pending | sample_clk_en;
            state_next   = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_l     <= '0;
         acc_r     <= '0;
         cnt       <= '0;
         sample_l  <= '0;
         sample_r  <= '0;
         frame_err <= 1'b0;
      end else begin
         if (frame_clr || beat_acc) begin
            acc_l <= acc_base_l + add_l;
            acc_r <= acc_base_r + add_r;
            cnt   <= beat_acc ? cnt_inc : '0;
         end
         if (load) begin
            sample_l <= sat_l;
            sample_r <= sat_r;
         end
         if (err_set) frame_err <= 1'b1;
      end
   end

   sample_saturate #(.IN_W(ACC_W), .OUT_W(SAMPLE_W)) u_sat_l (
      .din     (acc_l),
      .dout    (sat_l),
      .clipped (clip_l)
   );

   sample_saturate #(.IN_W(ACC_W), .OUT_W(SAMPLE_W)) u_sat_r (
      .din     (acc_r),
      .dout    (sat_r),
      .clipped (clip_r)
   );

`ifdef CHANNEL_ACCUMULATOR_CLIP_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clip_cnt <= '0;
      end else if (load && (clip_l || clip_r) && (clip_cnt != 16'hFFFF)) begin
         clip_cnt <= clip_cnt + 16'd1;
      end
   end
`else
   logic clip_unused;
   assign clip_unused = clip_l | clip_r;
`endif

endmodule

// File: tb/tb_channel_accumulator.sv
// tb_channel_accumulator: directed and randomized frames checked against a sum-and-clamp model.
module tb_channel_accumulator;

   localparam int NOPS = 36;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               sample_clk_en = 1'b0;
   logic               op_valid = 1'b0;
   logic signed [12:0] op_out = '0;
   logic               op_carrier = 1'b0;
   logic               op_left = 1'b0;
   logic               op_right = 1'b0;
   logic signed [15:0] sample_l, sample_r;
   logic               sample_valid, frame_err;
`ifdef CHANNEL_ACCUMULATOR_CLIP_CNT_EN
   logic [15:0]        clip_cnt;
`endif

   channel_accumulator #(.NUM_OPS(NOPS), .OP_W(13), .SAMPLE_W(16)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .sample_clk_en (sample_clk_en),
      .op_valid      (op_valid),
      .op_out        (op_out),
      .op_carrier    (op_carrier),
      .op_left       (op_left),
      .op_right      (op_right),
      .sample_l      (sample_l),
      .sample_r      (sample_r),
      .sample_valid  (sample_valid),
      .frame_err     (frame_err)
`ifdef CHANNEL_ACCUMULATOR_CLIP_CNT_EN
      ,
      .clip_cnt      (clip_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int val;
      bit car;
      bit l;
      bit r;
   } beat_t;

   beat_t  q[$];
   int     tests = 0;
   int     fails = 0;
   longint exp_l = 0, exp_r = 0;
   bit     exp_err = 1'b0;
   int     exp_clips = 0;

   function automatic longint clamp16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply inputs for one clock cycle, then settle 1ns past the edge.
   task automatic drive(input bit sce, input bit v, input int val,
                        input bit car, input bit l, input bit r);
      sample_clk_en = sce;
      op_valid      = v;
      op_out        = 13'(val);
      op_carrier    = car;
      op_left       = l;
      op_right      = r;
      @(posedge clk);
      #1;
      sample_clk_en = 1'b0;
      op_valid      = 1'b0;
   endtask

   task automatic fill(input int val, input bit alt_car, input bit l, input bit r);
      q.delete();
      for (int i = 0; i < NOPS; i++) begin
         beat_t b;
         b.val = val;
         b.car = alt_car ? bit'(i % 2) : 1'b1;
         b.l   = l;
         b.r   = r;
         q.push_back(b);
      end
   endtask

   // mode 0: separate open pulse; 1: open pulse with beat 1; 2: frame already open/pending.
   task automatic run_frame(input string tag, input int mode, input bit gaps, input bit sce_in_sat);
      longint sl = 0, sr = 0;
      int     early_valid = 0;
      foreach (q[i]) begin
         if (q[i].car && q[i].l) sl += q[i].val;
         if (q[i].car && q[i].r) sr += q[i].val;
      end
      if (mode == 0) drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < q.size(); i++) begin
         if (gaps && i > 0) begin
            repeat ($urandom_range(0, 2)) begin
               drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
               if (sample_valid) early_valid++;
            end
         end
         drive(mode == 1 && i == 0, 1'b1, q[i].val, q[i].car, q[i].l, q[i].r);
         if (sample_valid) early_valid++;
      end
      check({tag, "_early_valid"}, early_valid, 0);
      check({tag, "_held_l"}, sample_l, exp_l);
      drive(sce_in_sat, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      exp_l = clamp16(sl);
      exp_r = clamp16(sr);
      if (exp_l != sl || exp_r != sr) exp_clips++;
      check({tag, "_valid"}, sample_valid, 1);
      check({tag, "_l"}, sample_l, exp_l);
      check({tag, "_r"}, sample_r, exp_r);
      drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      check({tag, "_valid_drop"}, sample_valid, 0);
      check({tag, "_err"}, frame_err, exp_err);
   endtask

   initial begin
      #1_000_000;
      $error("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int valid_seen;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      check("rst_l", sample_l, 0);
      check("rst_r", sample_r, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_err", frame_err, 0);

      fill(100, 1'b0, 1'b1, 1'b1);
      run_frame("sum100", 0, 1'b0, 1'b0);

      fill(4095, 1'b0, 1'b1, 1'b0);
      run_frame("pos_clip", 0, 1'b0, 1'b0);
      fill(-4096, 1'b0, 1'b1, 1'b0);
      run_frame("neg_clip", 1, 1'b0, 1'b0);
`ifdef CHANNEL_ACCUMULATOR_CLIP_CNT_EN
      check("clip_cnt", clip_cnt, exp_clips);
`endif

      fill(10, 1'b1, 1'b1, 1'b1);
      run_frame("alt_car", 0, 1'b1, 1'b0);

      // Stray beat while idle: sticky error, no effect on the next frame.
      drive(1'b0, 1'b1, 1234, 1'b1, 1'b1, 1'b1);
      exp_err = 1'b1;
      check("stray_err", frame_err, 1);
      check("stray_held_l", sample_l, exp_l);
      fill(-7, 1'b0, 1'b1, 1'b1);
      run_frame("after_stray", 0, 1'b0, 1'b0);

      // Reset at beat 30: outputs clear without waiting for a clock edge.
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 500, 1'b1, 1'b1, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_l", sample_l, 0);
      check("arst_r", sample_r, 0);
      check("arst_valid", sample_valid, 0);
      check("arst_err", frame_err, 0);
      exp_l = 0;
      exp_r = 0;
      exp_err = 1'b0;
      exp_clips = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      valid_seen = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
         if (sample_valid) valid_seen++;
      end
      check("arst_no_valid", valid_seen, 0);
      fill(33, 1'b0, 1'b1, 1'b1);
      run_frame("post_rst", 0, 1'b0, 1'b0);

      // Abort after beat 20, then the restarted frame takes 36 fresh beats.
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 900, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      exp_err = 1'b1;
      check("abort_valid", sample_valid, 0);
      check("abort_err", frame_err, 1);
      check("abort_held_l", sample_l, exp_l);
      check("abort_held_r", sample_r, exp_r);
      fill(-55, 1'b0, 1'b0, 1'b1);
      run_frame("after_abort", 2, 1'b0, 1'b0);

      // Open pulse during SAT is held and starts the next frame on idle entry.
      fill(21, 1'b0, 1'b1, 1'b1);
      run_frame("sat_pulse", 0, 1'b0, 1'b1);
      fill(-300, 1'b0, 1'b1, 1'b0);
      run_frame("pending_frame", 2, 1'b0, 1'b0);

      for (int f = 0; f < 8; f++) begin
         bit big;
         big = ($urandom_range(0, 2) == 0);
         q.delete();
         for (int i = 0; i < NOPS; i++) begin
            beat_t b;
            b.val = big ? int'($urandom_range(3000, 4095))
                        : int'($urandom_range(0, 8191)) - 4096;
            b.car = ($urandom_range(0, 3) != 0);
            b.l   = $urandom_range(0, 1) == 1;
            b.r   = $urandom_range(0, 1) == 1;
            q.push_back(b);
         end
         run_frame($sformatf("rand%0d", f), int'($urandom_range(0, 1)),
                   $urandom_range(0, 1) == 1, 1'b0);
      end
`ifdef CHANNEL_ACCUMULATOR_CLIP_CNT_EN
      check("clip_cnt_final", clip_cnt, exp_clips);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
